// File: rtl/rps_matrix_scan.sv
// rps_matrix_scan: consumer of {result, user, fpga} game words that drives an
// 8x8 RGB matrix. Each word is shown as two 4x8 glyphs: the left half is the
// user's choice and the right half is the FPGA's choice. The colour channel
// encodes the result. Rows are scanned continuously, with a lit dwell followed
// by an all-off blanking gap. Optional feature macro: RPS_BLINK_EN makes
// user-win frames blink in blocks of BLINK_FRAMES frames.
//
// Handshake: a word transfers on a posedge where in_valid && in_ready. It is
// latched into the shadow buffer and in_ready is low from the next cycle.
// in_ready stays low until the shadow word moves to active at a frame
// boundary. The producer may change or drop its inputs freely while
// in_ready is low, because they are ignored.
//
// All outputs are registered. Registers are loaded from the next-cycle values
// of the scan state, so the pixel outputs always agree with the current scan
// state.
module rps_matrix_scan #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_result,
    input  logic [1:0] in_user,
    input  logic [1:0] in_fpga,
    output logic [2:0] A_count,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       E,
    output logic       frame_done,
    output logic       scan_state
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_t;

    // Stored words are {result, user, fpga}. The idle word displays nothing.
    localparam logic [5:0] IDLE_WORD = 6'b00_11_11;

    scan_t       state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  row_n;
    logic        boundary;

    logic [5:0]  active, active_n;
    logic [5:0]  shadow, shadow_n;
    logic        full, full_n;
    logic        accept, swap;
    logic        blink_off_n;

    logic [7:0]  pat;
    logic [7:0]  r_n, g_n, b_n;
    logic        fd_n;

    assign E          = 1'b1;
    assign in_ready   = ~full;
    assign scan_state = (state == ST_SHOW);

    // Each glyph is a 4-bit row slice. The msb is the leftmost column of its half.
    function automatic logic [3:0] glyph(input logic [1:0] choice, input logic [2:0] r);
        logic [3:0] g;
        g = 4'b0000;
        case (choice)
            2'b00:   g = (r < 3'd4) ? 4'b1001 : 4'b0110;                 // scissors
            2'b01:   g = (r >= 3'd2 && r <= 3'd5) ? 4'b0110 : 4'b0000;   // rock
            2'b10:   g = (r >= 3'd1 && r <= 3'd6) ? 4'b1111 : 4'b0000;   // paper
            default: g = 4'b0000;                                        // none
        endcase
        return g;
    endfunction

    // Scan FSM next state: blank gap, then lit dwell, then advance to the next row.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 16'd1;
        row_n    = A_count;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == 16'(BLANK_CYCLES - 1)) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == 16'(DWELL_CYCLES - 1)) begin
                    state_n  = ST_BLANK;
                    cnt_n    = '0;
                    row_n    = A_count + 3'd1;
                    boundary = (A_count == 3'd7);
                end
            end
            default: begin
                state_n = ST_BLANK;
                cnt_n   = '0;
            end
        endcase
    end

    // Double buffer: accept into shadow, and promote shadow to active only at a frame boundary.
    // Accept and swap never coincide, because an accept requires an empty shadow.
    always_comb begin
        accept   = in_valid & ~full;
        swap     = boundary & full;
        full_n   = full;
        active_n = active;
        shadow_n = shadow;
        if (swap) begin
            active_n = shadow;
            full_n   = 1'b0;
        end
        if (accept) begin
            shadow_n = {in_result, in_user, in_fpga};
            full_n   = 1'b1;
        end
    end

`ifdef RPS_BLINK_EN
    logic [15:0] blink_cnt, blink_cnt_n;
    logic        blink_off;

    // Blink phase: count frames since the last swap and toggle every BLINK_FRAMES frames.
    always_comb begin
        blink_cnt_n = blink_cnt;
        blink_off_n = blink_off;
        if (swap) begin
            blink_cnt_n = '0;
            blink_off_n = 1'b0;
        end else if (boundary) begin
            if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
                blink_cnt_n = '0;
                blink_off_n = ~blink_off;
            end else begin
                blink_cnt_n = blink_cnt + 16'd1;
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_n;
            blink_off <= blink_off_n;
        end
    end
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign blink_off_n      = 1'b0;
`endif

    // Pixel and frame-pulse values for the next cycle. Only the result's channel is driven.
    always_comb begin
        pat = {glyph(active_n[3:2], row_n), glyph(active_n[1:0], row_n)};
        r_n = 8'hFF;
        g_n = 8'hFF;
        b_n = 8'hFF;
        if (state_n == ST_SHOW && !(active_n[5:4] == 2'b10 && blink_off_n)) begin
            case (active_n[5:4])
                2'b01:   b_n = ~pat;
                2'b11:   r_n = ~pat;
                2'b10:   g_n = ~pat;
                default: ;
            endcase
        end
        fd_n = (state_n == ST_SHOW) && (row_n == 3'd7) && (cnt_n == 16'(DWELL_CYCLES - 1));
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            A_count    <= '0;
            active     <= IDLE_WORD;
            shadow     <= IDLE_WORD;
            full       <= 1'b0;
            R          <= 8'hFF;
            G          <= 8'hFF;
            B          <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            A_count    <= row_n;
            active     <= active_n;
            shadow     <= shadow_n;
            full       <= full_n;
            R          <= r_n;
            G          <= g_n;
            B          <= b_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_rps_matrix_scan.sv
// Bench for rps_matrix_scan: a random producer, a timeline reference model
// that pushes expected outputs every cycle, and a monitor that pops and compares.
module tb_rps_matrix_scan;

    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int BLINK  = 2;
    localparam int PERIOD = DWELL + BLANK;
    localparam int FRAME  = 8 * PERIOD;
    localparam int W      = 31;

    logic       clk;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_result, in_user, in_fpga;
    logic [2:0] A_count;
    logic [7:0] R, G, B;
    logic       E;
    logic       frame_done;
    logic       scan_state;

    rps_matrix_scan #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_user(in_user),
        .in_fpga(in_fpga),
        .A_count(A_count),
        .R(R),
        .G(G),
        .B(B),
        .E(E),
        .frame_done(frame_done),
        .scan_state(scan_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // reference model state: cycle index since reset, plus the buffered words
    int         t;
    logic [5:0] m_active, m_shadow;
    bit         m_full;
    int         m_since;
    bit         m_at_end, m_take;

    // glyph rows 0..7 indexed by choice code (scissors, rock, paper, none)
    logic [3:0] glyph_rom [4][8] = '{
        '{4'h9, 4'h9, 4'h9, 4'h9, 4'h6, 4'h6, 4'h6, 4'h6},
        '{4'h0, 4'h0, 4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'h0},
        '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0},
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}
    };

    function automatic logic [W-1:0] expect_now();
        int         ph, row;
        bit         show, fd, lit;
        logic [7:0] p, er, eg, eb;
        ph   = t % PERIOD;
        row  = (t / PERIOD) % 8;
        show = (ph >= BLANK);
        fd   = ((t % FRAME) == FRAME - 1);
        lit  = 1'b1;
`ifdef RPS_BLINK_EN
        if (m_active[5:4] == 2'b10 && ((m_since / BLINK) % 2) == 1) lit = 1'b0;
`endif
        er = 8'hFF;
        eg = 8'hFF;
        eb = 8'hFF;
        p  = {glyph_rom[m_active[3:2]][row], glyph_rom[m_active[1:0]][row]};
        if (show && lit) begin
            if (m_active[5:4] == 2'b01) eb = ~p;
            if (m_active[5:4] == 2'b11) er = ~p;
            if (m_active[5:4] == 2'b10) eg = ~p;
        end
        return {show, ~m_full, 3'(row), er, eg, eb, fd, 1'b1};
    endfunction

    // reference model: advance one cycle per posedge and push the expected outputs
    always @(posedge clk) begin
        if (clear) begin
            t        = 0;
            m_active = 6'b00_11_11;
            m_shadow = 6'b00_11_11;
            m_full   = 1'b0;
            m_since  = 0;
        end else begin
            m_at_end = ((t % FRAME) == FRAME - 1);
            m_take   = in_valid && !m_full;
            if (m_at_end) begin
                if (m_full) begin
                    m_active = m_shadow;
                    m_full   = 1'b0;
                    m_since  = 0;
                end else begin
                    m_since = m_since + 1;
                end
            end
            if (m_take) begin
                m_shadow = {in_result, in_user, in_fpga};
                m_full   = 1'b1;
            end
            t = t + 1;
        end
        exp_q.push_back(expect_now());
    end

    // monitor: pop and compare once per cycle, away from the active edge
    always @(negedge clk) begin
        logic [W-1:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {scan_state, in_ready, A_count, R, G, B, frame_done, E};
            checks = checks + 1;
            if (g !== e) begin
                failures = failures + 1;
                $display("FAIL scan t=%0d got{st,rdy,A,R,G,B,fd,E}=%h expected=%h", t, g, e);
            end
        end
    end

    // driver tasks
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic random_traffic(input int n, input int busy);
        repeat (n) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 15) < busy);
            in_result = 2'($urandom_range(0, 3));
            in_user   = 2'($urandom_range(0, 3));
            in_fpga   = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic pulse_clear(input int n);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Offer a word exactly on the frame-boundary cycle while the shadow is empty.
    task automatic offer_on_boundary(input logic [5:0] w);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if ((t % FRAME) == FRAME - 1 && !m_full) begin
                {in_result, in_user, in_fpga} = w;
                in_valid = 1'b1;
                done     = 1'b1;
            end
        end
        checks = checks + 1;
        if (!done) begin
            failures = failures + 1;
            $display("FAIL boundary_offer never_found=1 required_found=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // stimulus
    initial begin
        clear     = 1'b1;
        in_valid  = 1'b0;
        in_result = 2'b00;
        in_user   = 2'b00;
        in_fpga   = 2'b00;
        repeat (3) @(negedge clk);
        clear = 1'b0;

        idle_cycles(FRAME + 5);
        random_traffic(6 * FRAME, 2);
        offer_on_boundary(6'b01_10_10);
        idle_cycles(2 * FRAME);
        random_traffic(4 * FRAME, 15);
        random_traffic($urandom_range(20, 60), 4);
        pulse_clear($urandom_range(1, 3));
        random_traffic(5 * FRAME, 6);
        offer_on_boundary(6'b10_01_00);
        idle_cycles(7 * FRAME);
        random_traffic(3 * FRAME, 3);
        pulse_clear(3);
        idle_cycles(FRAME + 3);
        random_traffic(6 * FRAME, 8);
        idle_cycles(3);

        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
